// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared datapath command, line status and controller FSM encodings
// Revision  : 1.0
// ============================================================================
package cache_pkg;

    localparam logic [1:0] P_READ  = 2'b00;
    localparam logic [1:0] P_WRITE = 2'b01;
    localparam logic [1:0] B_READ  = 2'b10;
    localparam logic [1:0] B_WRITE = 2'b11;

    // {valid, dirty} line status as reported by the datapath
    localparam logic [1:0] EXCL = 2'b11;
    localparam logic [1:0] SHRD = 2'b10;
    localparam logic [1:0] INVL = 2'b00;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOOKUP    = 4'd1,
        S_ARB       = 4'd2,
        S_WB        = 4'd3,
        S_SNOOP     = 4'd4,
        S_FILL      = 4'd5,
        S_FILL_PEER = 4'd6,
        S_WRITE     = 4'd7,
        S_DONE      = 4'd8,
        S_ERR       = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
// mem_watchdog : counts bus-transfer cycles without mem_ack, flags expiry
// Revision     : 1.0
// ============================================================================
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic ack,
    output logic expired
);

    localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

    logic [W-1:0] count;

    // Expiry fires in the MEM_TIMEOUT-th unacknowledged cycle; an ack that
    // same cycle suppresses it.
    assign expired = enable && !ack && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !ack && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// cache_controller : MSI control FSM sequencing the cache datapath and bus
// Revision         : 1.0
// ============================================================================
module cache_controller
    import cache_pkg::*;
#(
    parameter int SNOOP_LAT   = 1,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_req,
    input  logic       p_rw,
    input  logic       read_hit,
    input  logic       write_hit,
    input  logic [1:0] stat,
    input  logic       snoop_hit_in,
    input  logic       bus_gnt,
    input  logic       mem_ack,
    output logic [1:0] func,
    output logic       snoop_out,
    output logic       bus_req,
    output logic       p_ready,
    output logic       p_err,
    output logic       busy
);

    localparam logic [1:0] SNOOP_LAST = 2'(SNOOP_LAT - 1);

    state_t     state, next_state;
    logic       is_store;
    logic       wb_pend;
    logic [1:0] snoop_cnt;
    logic       wd_active;
    logic       wd_expired;
    logic       hit;

    logic [1:0] func_nx;
    logic       snoop_out_nx, bus_req_nx, p_ready_nx, p_err_nx, busy_nx;

    // write_hit implies read_hit, so either marks a tag hit
    assign hit       = read_hit || write_hit;
    assign wd_active = (state == S_WB) || (state == S_FILL);

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!wd_active),
        .enable  (wd_active),
        .ack     (mem_ack),
        .expired (wd_expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (p_req) next_state = S_LOOKUP;
            S_LOOKUP:    if (hit) next_state = is_store ? S_WRITE : S_DONE;
                         else     next_state = S_ARB;
            S_ARB:       if (bus_gnt) next_state = wb_pend ? S_WB : S_SNOOP;
            S_WB:        if (mem_ack)         next_state = S_SNOOP;
                         else if (wd_expired) next_state = S_ERR;
            S_SNOOP:     if (snoop_cnt == SNOOP_LAST)
                             next_state = snoop_hit_in ? S_FILL_PEER : S_FILL;
            S_FILL:      if (mem_ack)         next_state = is_store ? S_WRITE : S_DONE;
                         else if (wd_expired) next_state = S_ERR;
            S_FILL_PEER: next_state = is_store ? S_WRITE : S_DONE;
            S_WRITE:     next_state = S_DONE;
            S_DONE:      next_state = S_IDLE;
            S_ERR:       next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        func_nx      = P_READ;
        snoop_out_nx = 1'b0;
        bus_req_nx   = 1'b0;
        p_ready_nx   = 1'b0;
        p_err_nx     = 1'b0;
        busy_nx      = (next_state != S_IDLE);
        case (next_state)
            S_ARB:       bus_req_nx = 1'b1;
            S_WB:        begin func_nx = B_WRITE; bus_req_nx = 1'b1; end
            S_SNOOP:     begin snoop_out_nx = 1'b1; bus_req_nx = 1'b1; end
            S_FILL:      begin func_nx = B_READ; bus_req_nx = 1'b1; end
            S_FILL_PEER: begin func_nx = B_READ; bus_req_nx = 1'b1; end
            S_WRITE:     func_nx = P_WRITE;
            S_DONE:      p_ready_nx = 1'b1;
            S_ERR:       p_err_nx = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            is_store  <= 1'b0;
            wb_pend   <= 1'b0;
            snoop_cnt <= 2'd0;
            func      <= P_READ;
            snoop_out <= 1'b0;
            bus_req   <= 1'b0;
            p_ready   <= 1'b0;
            p_err     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            if (state == S_IDLE && p_req) is_store <= p_rw;
            if (state == S_LOOKUP)        wb_pend  <= (stat == EXCL);
            snoop_cnt <= (state == S_SNOOP) ? snoop_cnt + 2'd1 : 2'd0;
            func      <= func_nx;
            snoop_out <= snoop_out_nx;
            bus_req   <= bus_req_nx;
            p_ready   <= p_ready_nx;
            p_err     <= p_err_nx;
            busy      <= busy_nx;
        end
    end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
# cache_controller

Per-cache MSI control FSM sitting directly upstream of `cache_datapath`. It accepts processor load/store requests, interprets the datapath's hit and status flags, and sequences the `func`/`snoop_out` commands that drive the datapath. It also handles bus arbitration, dirty-victim write-back, peer snoop and line fill. One instance per cache; all outputs are registered.

## Interface
Parameters:
- `SNOOP_LAT`, default 1: cycles `snoop_out` is held before `snoop_hit_in` is sampled (1..3).
- `MEM_TIMEOUT`, default 255: maximum cycles waited for `mem_ack` in WB/FILL before aborting (8-bit counter).

Ports:
- `clk`  in  1  — sole clock, rising edge.
- `reset`  in  1  — asynchronous, active-low; all state and outputs cleared immediately on assertion.
- `p_req`  in  1  — processor request valid; held high until `p_ready` or `p_err`.
- `p_rw`  in  1  — 0 = load, 1 = store; sampled only on IDLE→LOOKUP.
- `read_hit`  in  1  — from datapath: valid && tag match.
- `write_hit`  in  1  — from datapath: valid && tag match && dirty.
- `stat`  in  2  — from datapath: {valid, dirty} of the indexed line.
- `snoop_hit_in`  in  1  — a peer cache holds the requested line.
- `bus_gnt`  in  1  — bus grant from arbiter, level.
- `mem_ack`  in  1  — memory completed the current bus transfer.
- `func`  out  2  — datapath command: 00 p_read, 01 p_write, 10 b_read, 11 b_write.
- `snoop_out`  out  1  — drive request address onto snoop bus.
- `bus_req`  out  1  — bus request to arbiter.
- `p_ready`  out  1  — one-cycle completion pulse.
- `p_err`  out  1  — one-cycle abort pulse (memory timeout).
- `busy`  out  1  — FSM not in IDLE.

## Operation
- Reset values: `func`=00, all other outputs 0, state IDLE, counters 0.
- `func` is 00 (p_read) in every state not listed below. It is 01 for exactly one cycle per store.
- States and transitions:
  - IDLE: on `p_req`, latch `p_rw` and go to LOOKUP.
  - LOOKUP (1 cycle), evaluated on the current flags:
    - load && `read_hit` → DONE.
    - store && `read_hit` → WRITE. This covers both clean-shared and dirty; the datapath raises invalidate.
    - miss && `stat`==11 → ARB with `wb_pend`=1.
    - any other miss → ARB with `wb_pend`=0.
  - ARB: `bus_req`=1 until `bus_gnt`, then go to WB if `wb_pend`, else SNOOP.
  - WB: `func`=11 until `mem_ack`, then SNOOP.
  - SNOOP: `snoop_out`=1 for `SNOOP_LAT` cycles; sample `snoop_hit_in` in the last of those cycles. Hit → FILL_PEER; miss → FILL.
  - FILL: `func`=10 until `mem_ack`. The datapath captures the line on the `mem_ack` edge. Then go to WRITE if store, else DONE.
  - FILL_PEER: `func`=10 for exactly one cycle with no `mem_ack` wait; the peer sources the bus data. Then go to WRITE if store, else DONE.
  - WRITE: `func`=01 for one cycle, then DONE.
  - DONE: `p_ready`=1 for one cycle, then IDLE.
  - ERR: `p_err`=1 for one cycle, then IDLE.
- `bus_req` stays high from ARB entry through the last cycle of FILL or FILL_PEER, and is low in WRITE, DONE and ERR.
- Timeout counter:
  - Clears on entry to WB and on entry to FILL; increments each cycle without `mem_ack`.
  - Reaching `MEM_TIMEOUT` → ERR. The line is left unmodified, apart from any write-back already done.
- Boundary rules:
  - `p_req` dropping mid-transaction is ignored; the transaction completes.
  - `mem_ack` outside WB/FILL is ignored.
  - `bus_gnt` is assumed held while `bus_req` is high; loss of grant is not checked.
  - `mem_ack` and timeout in the same cycle: `mem_ack` wins.
  - Reset asserted mid-operation drops `bus_req`/`snoop_out` immediately and returns to IDLE with no `p_ready`.
  - A new `p_req` is accepted in the cycle after DONE or ERR at the earliest.

## Timing
- Request edge = cycle 0.
- Load hit: LOOKUP in cycle 1, `p_ready` in cycle 2. The datapath `p_data` is valid from cycle 2.
- Store hit: `func`=01 in cycle 2, `p_ready` in cycle 3.
- Clean miss, immediate grant, `SNOOP_LAT`=1, peer miss, `mem_ack` on first FILL cycle: ARB 2, SNOOP 3, FILL 4, `p_ready` 5.
- Each dirty victim adds WB cycles; each extra `SNOOP_LAT` adds one cycle.

## Structure
- Shared package `cache_pkg` holds:
  - `func` encodings P_READ/P_WRITE/B_READ/B_WRITE.
  - Status encodings EXCL=11, SHRD=10, INVL=00 (shared with the datapath).
  - FSM state enum.
- One sub-module, `mem_watchdog`: clear/enable/ack inputs, `expired` output, width set by `MEM_TIMEOUT`.

## Test plan
- Load, `read_hit`=1 → `p_ready` in cycle 2, `func`=00 throughout, `bus_req` never high.
- Store, `read_hit`=1, `stat`=10 → `func`=01 in exactly cycle 2, `p_ready` in cycle 3.
- Load miss, `stat`=11, `bus_gnt` after 3 cycles, `mem_ack` after 2 cycles in WB and 1 in FILL → sequence ARB×3, `func`=11×2, `snoop_out`×1, `func`=10×1, `p_ready`; `bus_req` continuous from ARB through FILL.
- Store miss, `stat`=00, `snoop_hit_in`=1 → `func`=10 for one cycle (no `mem_ack`), then `func`=01, then `p_ready`.
- Load miss, `mem_ack` never asserted, `MEM_TIMEOUT`=8 → `p_err` after 8 FILL cycles, `bus_req` low and `busy` low the next cycle.
- Reset pulsed during WB → `func`=00 and `bus_req`=0 asynchronously; after release, a new load hit completes in 2 cycles.
